// File: rtl/vga_out_pkg.sv
// Shared types and constants for the TinyVGA output stage.
package vga_out_pkg;

  localparam int LVL_W = 2;

  typedef enum logic [1:0] {
    FS_BLACK    = 2'd0,
    FS_FADE_IN  = 2'd1,
    FS_SHOW     = 2'd2,
    FS_FADE_OUT = 2'd3
  } fade_state_e;

  // TinyVGA PMOD bit positions: {hs,B0,G0,R0,vs,B1,G1,R1}
  localparam int UO_R1 = 0;
  localparam int UO_G1 = 1;
  localparam int UO_B1 = 2;
  localparam int UO_VS = 3;
  localparam int UO_R0 = 4;
  localparam int UO_G0 = 5;
  localparam int UO_B0 = 6;
  localparam int UO_HS = 7;

  // Idle pin word: both syncs deasserted (high), colour black
  localparam logic [7:0] UO_RESET = 8'h88;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } pix_t;

  localparam int PIX_W = $bits(pix_t);

  localparam pix_t PIX_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0,
                               r: 2'd0, g: 2'd0, b: 2'd0};

  // Cap one colour channel at the current intensity level
  function automatic logic [1:0] clamp_lvl(input logic [1:0] c,
                                           input logic [LVL_W-1:0] lvl);
    return (c > lvl) ? lvl : c;
  endfunction

endpackage

// File: rtl/vga_pixel_pipe.sv
// Fixed-depth register chain carrying syncs, DE and colour together so
// every field sees identical latency.
module vga_pixel_pipe
  import vga_out_pkg::*;
#(
  parameter int               DEPTH   = 1,
  parameter logic [PIX_W-1:0] RST_VAL = PIX_RST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] q
);

  logic [DEPTH-1:0][PIX_W-1:0] stg;

  // Shift the pixel word one stage per clock; reset flushes every stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg <= {DEPTH{RST_VAL}};
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/vga_fade_output_stage.sv
// Output stage between renderer and TinyVGA PMOD: pipelined colour/sync,
// black outside the active area, and a frame-driven fade FSM that caps
// colour intensity. Level changes commit on the vsync falling edge, which
// sits inside vertical blank, so a frame is never drawn at two levels.
module vga_fade_output_stage
  import vga_out_pkg::*;
#(
  parameter int PIPE_STAGES  = 1,
  parameter int BLACK_FRAMES = 30,
  parameter int STEP_FRAMES  = 8,
  parameter int SHOW_FRAMES  = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] in_r,
  input  logic [1:0] in_g,
  input  logic [1:0] in_b,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_de,
  input  logic       fade_en,
  output logic [7:0] uo_out,
  output logic       de_out,
  output logic       frame_tick,
  output logic [1:0] fade_level,
  output logic [1:0] fade_state
);

  localparam logic [7:0] BLACK_LAST = 8'(BLACK_FRAMES - 1);
  localparam logic [7:0] STEP_LAST  = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] SHOW_LAST  = 8'(SHOW_FRAMES - 1);

  pix_t pix_in, pix_out;

  assign pix_in = '{hs: in_hsync, vs: in_vsync, de: in_de,
                    r: in_r, g: in_g, b: in_b};

  vga_pixel_pipe #(.DEPTH(PIPE_STAGES), .RST_VAL(PIX_RST)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pix_in),
    .q     (pix_out)
  );

  fade_state_e      state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             vs_prev_q;
  logic             tick_q;
  logic             frame_edge;
  logic [LVL_W-1:0] lvl_inc, lvl_dec;

  // Frame boundary is the raw vsync falling edge
  assign frame_edge = !in_vsync && vs_prev_q;
  assign lvl_inc    = lvl_q + 2'd1;
  assign lvl_dec    = lvl_q - 2'd1;

  // FSM, level, counter, edge detector and tick registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FS_BLACK;
      lvl_q     <= '0;
      cnt_q     <= '0;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      cnt_q     <= cnt_d;
      vs_prev_q <= in_vsync;
      tick_q    <= frame_edge;
    end
  end

  // Next state: fade_en=0 pins full brightness every cycle, otherwise
  // advance once per frame edge
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    if (!fade_en) begin
      state_d = FS_SHOW;
      lvl_d   = 2'd3;
      cnt_d   = '0;
    end else if (frame_edge) begin
      unique case (state_q)
        FS_BLACK: begin
          if (cnt_q == BLACK_LAST) begin
            state_d = FS_FADE_IN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        FS_FADE_IN: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            lvl_d = lvl_inc;
            if (lvl_inc == 2'd3) state_d = FS_SHOW;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        FS_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = FS_FADE_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        FS_FADE_OUT: begin
          if (cnt_q == STEP_LAST) begin
            cnt_d = '0;
            lvl_d = lvl_dec;
            if (lvl_dec == 2'd0) state_d = FS_BLACK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = FS_BLACK;
          lvl_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  logic [1:0] r_o, g_o, b_o;

  // Clamp at the last stage using the live level; blank when DE is low
  always_comb begin
    r_o = pix_out.de ? clamp_lvl(pix_out.r, lvl_q) : 2'd0;
    g_o = pix_out.de ? clamp_lvl(pix_out.g, lvl_q) : 2'd0;
    b_o = pix_out.de ? clamp_lvl(pix_out.b, lvl_q) : 2'd0;
  end

  // Scatter colour MSB/LSB and syncs onto the PMOD pin order
  always_comb begin
    uo_out        = '0;
    uo_out[UO_HS] = pix_out.hs;
    uo_out[UO_VS] = pix_out.vs;
    uo_out[UO_R1] = r_o[1];
    uo_out[UO_G1] = g_o[1];
    uo_out[UO_B1] = b_o[1];
    uo_out[UO_R0] = r_o[0];
    uo_out[UO_G0] = g_o[0];
    uo_out[UO_B0] = b_o[0];
  end

  assign de_out     = pix_out.de;
  assign frame_tick = tick_q;
  assign fade_level = lvl_q;
  assign fade_state = state_q;

endmodule

// File: tb/tb_vga_fade_output_stage.sv
// Directed bench for vga_fade_output_stage. A queue holds the pixels
// currently inside the pipeline (pushed when the DUT captures them, popped
// when they reach the pins); a small fade model supplies the expected
// level and state each cycle.
module tb_vga_fade_output_stage;

  localparam int PIPE = 3;
  localparam int BF   = 1;
  localparam int SF   = 1;
  localparam int SHF  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_r, in_g, in_b;
  logic       in_hsync, in_vsync, in_de, fade_en;
  logic [7:0] uo_out, uo_out2;
  logic       de_out, de_out2, frame_tick, frame_tick2;
  logic [1:0] fade_level, fade_level2, fade_state, fade_state2;

  always #20 clk = ~clk;

  vga_fade_output_stage #(.PIPE_STAGES(PIPE), .BLACK_FRAMES(BF),
                          .STEP_FRAMES(SF), .SHOW_FRAMES(SHF)) dut (
    .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .fade_en(fade_en), .uo_out(uo_out), .de_out(de_out),
    .frame_tick(frame_tick), .fade_level(fade_level), .fade_state(fade_state)
  );

  // Second instance with a two-frame SHOW for the fade_en override test
  vga_fade_output_stage #(.PIPE_STAGES(PIPE), .BLACK_FRAMES(1),
                          .STEP_FRAMES(1), .SHOW_FRAMES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .fade_en(fade_en), .uo_out(uo_out2), .de_out(de_out2),
    .frame_tick(frame_tick2), .fade_level(fade_level2), .fade_state(fade_state2)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int n_ticks = 0;

  // pixel word {hs,vs,de,r,g,b}
  logic [8:0] pq[$];
  localparam logic [8:0] RST_PIX = 9'b110_00_00_00;

  // fade model (state: 0 BLACK, 1 FADE_IN, 2 SHOW, 3 FADE_OUT)
  logic [1:0] m_st, m_lv;
  int         m_cnt;
  logic       m_vsp, m_tick;

  localparam logic [1:0] ST_TAB [9] = '{1, 1, 1, 2, 3, 3, 3, 0, 1};
  localparam logic [1:0] LV_TAB [9] = '{0, 1, 2, 3, 3, 2, 1, 0, 0};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cmin(input logic [1:0] c, input logic [1:0] l);
    return (c < l) ? c : l;
  endfunction

  // {MSB,LSB} of one channel from the pin word
  function automatic logic [1:0] chan(input logic [7:0] uo, input int msb, input int lsb);
    return {uo[msb], uo[lsb]};
  endfunction

  // One clock: capture inputs into scoreboard and model, then check outputs
  task automatic cyc();
    logic [8:0] e;
    logic [1:0] cr, cg, cb;
    logic       edg;
    @(posedge clk);
    if (!rst_n) begin
      pq.delete();
      repeat (PIPE) pq.push_back(RST_PIX);
      m_st = 0; m_lv = 0; m_cnt = 0; m_vsp = 1'b1; m_tick = 1'b0;
    end else begin
      pq.push_back({in_hsync, in_vsync, in_de, in_r, in_g, in_b});
      edg    = !in_vsync && m_vsp;
      m_tick = edg;
      m_vsp  = in_vsync;
      if (!fade_en) begin
        m_st = 2; m_lv = 3; m_cnt = 0;
      end else if (edg) begin
        case (m_st)
          2'd0: if (m_cnt == BF-1)  begin m_st = 1; m_cnt = 0; end else m_cnt++;
          2'd1: if (m_cnt == SF-1)  begin m_cnt = 0; m_lv = m_lv + 2'd1; if (m_lv == 3) m_st = 2; end
                else m_cnt++;
          2'd2: if (m_cnt == SHF-1) begin m_st = 3; m_cnt = 0; end else m_cnt++;
          default: if (m_cnt == SF-1) begin m_cnt = 0; m_lv = m_lv - 2'd1; if (m_lv == 0) m_st = 0; end
                   else m_cnt++;
        endcase
      end
    end
    @(negedge clk);
    if (pq.size() == 0) begin
      n_vec++; n_err++;
      $error("FAIL sb_empty observed=0 expected=%0d", PIPE);
    end else begin
      e  = pq.pop_front();
      cr = e[6] ? cmin(e[5:4], m_lv) : 2'd0;
      cg = e[6] ? cmin(e[3:2], m_lv) : 2'd0;
      cb = e[6] ? cmin(e[1:0], m_lv) : 2'd0;
      chk("sb_uo", uo_out, {e[8], cb[0], cg[0], cr[0], e[7], cb[1], cg[1], cr[1]});
      chk("sb_de", {7'd0, de_out}, {7'd0, e[6]});
    end
    chk("sb_tick",  {7'd0, frame_tick}, {7'd0, m_tick});
    chk("sb_state", {6'd0, fade_state}, {6'd0, m_st});
    chk("sb_level", {6'd0, fade_level}, {6'd0, m_lv});
    if (frame_tick) n_ticks++;
  endtask

  // One frame: a single vsync-low cycle (the edge) then idle cycles
  task automatic frame(input int idle);
    in_vsync = 1'b0;
    cyc();
    in_vsync = 1'b1;
    repeat (idle) cyc();
  endtask

  initial begin
    rst_n = 1'b0; fade_en = 1'b0; in_de = 1'b1;
    in_r = 2'd3; in_g = 2'd3; in_b = 2'd3;
    in_hsync = 1'b1; in_vsync = 1'b1;

    // reset holds idle pins despite active input
    repeat (5) begin
      cyc();
      chk("rst_uo", uo_out, 8'h88);
      chk("rst_de", {7'd0, de_out}, 8'd0);
      chk("rst_state", {6'd0, fade_state}, 8'd0);
      chk("rst_level", {6'd0, fade_level}, 8'd0);
    end

    // release with fade_en=0: full brightness, flush pipeline
    rst_n = 1'b1; in_de = 1'b0; in_r = 0; in_g = 0; in_b = 0;
    repeat (4) cyc();
    chk("fen0_state", {6'd0, fade_state}, 8'd2);
    chk("fen0_level", {6'd0, fade_level}, 8'd3);

    // single-cycle R=2 with hsync pulse: exactly PIPE cycles latency
    in_r = 2'd2; in_de = 1'b1; in_hsync = 1'b0;
    cyc();
    in_r = 2'd0; in_de = 1'b0; in_hsync = 1'b1;
    cyc();
    chk("lat_early_de", {7'd0, de_out}, 8'd0);
    cyc();
    chk("lat_r_hs", {5'd0, uo_out[7], uo_out[4], uo_out[0]}, 8'b001);
    chk("lat_de", {7'd0, de_out}, 8'd1);
    cyc();
    chk("lat_after", uo_out, 8'h88);

    // vsync pulse delayed identically
    in_vsync = 1'b0; cyc(); in_vsync = 1'b1;
    repeat (2) cyc();
    chk("lat_vs", {7'd0, uo_out[3]}, 8'd0);
    cyc();

    // DE low blanks colour while syncs pass
    in_de = 1'b0; in_r = 3; in_g = 3; in_b = 3; in_hsync = 1'b0;
    repeat (3) cyc();
    chk("blank_col", uo_out & 8'h77, 8'h00);
    chk("blank_hs", {7'd0, uo_out[7]}, 8'd0);
    in_hsync = 1'b1;
    repeat (4) begin
      in_de = ~in_de; in_r = 2'($urandom_range(0, 3)); in_g = 2'($urandom_range(0, 3));
      in_b = 2'($urandom_range(0, 3));
      cyc();
    end

    // fade sequence from reset, all frame parameters 1
    rst_n = 1'b0; repeat (2) cyc();
    rst_n = 1'b1; fade_en = 1'b1; in_de = 1'b1;
    in_r = 2'd3; in_g = 2'd2; in_b = 2'd1;
    cyc();
    n_ticks = 0;
    for (int t = 0; t < 9; t++) begin
      frame(0);
      chk("seq_tick",  {7'd0, frame_tick}, 8'd1);
      chk("seq_state", {6'd0, fade_state}, {6'd0, ST_TAB[t]});
      chk("seq_level", {6'd0, fade_level}, {6'd0, LV_TAB[t]});
      repeat (3) cyc();
      chk("seq_tick_low", {7'd0, frame_tick}, 8'd0);
      if (t == 1) begin
        chk("clamp1_r", {6'd0, chan(uo_out, 0, 4)}, 8'd1);
        chk("clamp1_g", {6'd0, chan(uo_out, 1, 5)}, 8'd1);
        chk("clamp1_b", {6'd0, chan(uo_out, 2, 6)}, 8'd1);
      end
      if (t == 2) begin
        chk("clamp2_r", {6'd0, chan(uo_out, 0, 4)}, 8'd2);
        chk("clamp2_g", {6'd0, chan(uo_out, 1, 5)}, 8'd2);
        chk("clamp2_b", {6'd0, chan(uo_out, 2, 6)}, 8'd1);
      end
    end
    cyc();
    chk("seq_ticks", 8'(n_ticks), 8'd9);

    // fade_en drop coincident with an edge while dut2 is in FADE_OUT level 2
    rst_n = 1'b0; repeat (2) cyc();
    rst_n = 1'b1; cyc();
    repeat (7) frame(2);
    chk("ovr_pre_state", {6'd0, fade_state2}, 8'd3);
    chk("ovr_pre_level", {6'd0, fade_level2}, 8'd2);
    fade_en = 1'b0;
    in_vsync = 1'b0;
    cyc();
    fade_en = 1'b1; in_vsync = 1'b1;
    chk("ovr_tick",  {7'd0, frame_tick2}, 8'd1);
    chk("ovr_state", {6'd0, fade_state2}, 8'd2);
    chk("ovr_level", {6'd0, fade_level2}, 8'd3);
    repeat (2) cyc();
    frame(2);
    chk("ovr_show1", {6'd0, fade_state2}, 8'd2);
    frame(2);
    chk("ovr_fo_state", {6'd0, fade_state2}, 8'd3);
    chk("ovr_fo_level", {6'd0, fade_level2}, 8'd3);

    // mid-frame reset clears pipeline contents next edge
    in_de = 1'b1; in_hsync = 1'b0; cyc(); cyc();
    rst_n = 1'b0; cyc();
    chk("midrst_uo", uo_out, 8'h88);
    chk("midrst_state", {6'd0, fade_state}, 8'd0);
    rst_n = 1'b1; in_hsync = 1'b1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run can never hang
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
